// File: rtl/led_arbiter.sv
// -----------------------------------------------------------------------------
// led_arbiter
//   Round-robin arbiter that lends the 24 Io LEDs to one of four sources for a
//   time slice of DWELL_CYCLES clocks. The grant rotates only at slice expiry.
//   If the granted source drops its request, the grant is released and the
//   block re-arbitrates one cycle later. A freeze input stops the slice timer.
//
// Ports
//   clk        in   1   rising-edge clock (100 MHz onboard)
//   rst        in   1   synchronous, active-high reset
//   req        in   4   request bit per source
//   src_data   in  96   source i pattern in bits [24i+23:24i]
//   freeze     in   1   high = dwell counter holds, no rotation
//   grant      out  4   registered one-hot grant (zero when idle)
//   grant_id   out  2   registered granted index (zero when idle)
//   io_led     out 24   registered LED pattern, one cycle behind grant
//   dbg_state  out  1   FSM state (0 = IDLE, 1 = HOLD)
//   dbg_cnt    out 26   dwell counter
//
// Handshake: req is level-sensitive. A source keeps req high for as long as it
// wants the LEDs; grant is the only acknowledgement and there is no ready path.
// -----------------------------------------------------------------------------
module led_arbiter #(
    parameter int DWELL_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [95:0] src_data,
    input  logic        freeze,
    output logic [3:0]  grant,
    output logic [1:0]  grant_id,
    output logic [23:0] io_led,
    output logic        dbg_state,
    output logic [25:0] dbg_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [25:0] CNT_LAST = 26'(DWELL_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [25:0] r_cnt;
    logic [3:0]  r_grant;
    logic [1:0]  r_grant_id;
    logic [23:0] r_io_led;

    state_t      w_state_nxt;
    logic [1:0]  w_ptr_nxt;
    logic [25:0] w_cnt_nxt;
    logic [3:0]  w_grant_nxt;
    logic [1:0]  w_grant_id_nxt;
    logic [23:0] w_io_led_nxt;

    logic [3:0]  w_search_req;
    logic        w_pick_valid;
    logic [1:0]  w_pick_id;
    logic [1:0]  w_idx;

    // Round-robin search starting at ptr+1. In HOLD, ptr equals the granted
    // index, so masking the current grant out of req leaves exactly the
    // "other pending requesters" in the same search order.
    always_comb begin
        w_search_req = (r_state == S_HOLD) ? (req & ~r_grant) : req;
        w_pick_valid = 1'b0;
        w_pick_id    = r_ptr;
        w_idx        = r_ptr;
        // Scan from the far end back towards ptr+1 so the nearest hit wins.
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_search_req[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick_id    = w_idx;
            end
        end
    end

    // Next-state / next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = r_grant;
        w_grant_id_nxt = r_grant_id;

        case (r_state)
            S_IDLE: begin
                w_cnt_nxt      = '0;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
                if (w_pick_valid) begin
                    w_state_nxt    = S_HOLD;
                    w_ptr_nxt      = w_pick_id;
                    w_grant_nxt    = 4'b0001 << w_pick_id;
                    w_grant_id_nxt = w_pick_id;
                end
            end
            S_HOLD: begin
                // Release beats expiry and freeze.
                if (!req[r_grant_id]) begin
                    w_state_nxt    = S_IDLE;
                    w_cnt_nxt      = '0;
                    w_grant_nxt    = '0;
                    w_grant_id_nxt = '0;
                end else if (freeze) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_pick_valid) begin
                        w_ptr_nxt      = w_pick_id;
                        w_grant_nxt    = 4'b0001 << w_pick_id;
                        w_grant_id_nxt = w_pick_id;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 26'd1;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_cnt_nxt      = '0;
                w_grant_nxt    = '0;
                w_grant_id_nxt = '0;
            end
        endcase
    end

    // LEDs follow the grant currently registered, hence the one-cycle lag.
    always_comb begin
        w_io_led_nxt = '0;
        if (r_grant != 4'b0000) begin
            case (r_grant_id)
                2'd0:    w_io_led_nxt = src_data[23:0];
                2'd1:    w_io_led_nxt = src_data[47:24];
                2'd2:    w_io_led_nxt = src_data[71:48];
                default: w_io_led_nxt = src_data[95:72];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd3;   // first search then starts at source 0
            r_cnt      <= '0;
            r_grant    <= '0;
            r_grant_id <= '0;
            r_io_led   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_io_led   <= w_io_led_nxt;
        end
    end

    assign grant     = r_grant;
    assign grant_id  = r_grant_id;
    assign io_led    = r_io_led;
    assign dbg_state = (r_state == S_HOLD);
    assign dbg_cnt   = r_cnt;

endmodule

// File: tb/tb_led_arbiter.sv
// -----------------------------------------------------------------------------
// tb_led_arbiter
//   Directed scenarios for the documented corner cases followed by random
//   traffic, every cycle compared against a behavioural model of the arbiter.
// -----------------------------------------------------------------------------
module tb_led_arbiter;

    localparam int DWELL = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [95:0] src_data;
    logic        freeze;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic [23:0] io_led;
    logic        dbg_state;
    logic [25:0] dbg_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: granted source as an int (-1 = nobody), last winner,
    // elapsed slice time and the LED value.
    int          m_gid;
    int          m_ptr;
    int          m_cnt;
    logic [23:0] m_led;

    led_arbiter #(.DWELL_CYCLES(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .freeze    (freeze),
        .grant     (grant),
        .grant_id  (grant_id),
        .io_led    (io_led),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Nearest requester after 'from' going round the ring; 'excl' is skipped.
    function automatic int next_requester(input logic [3:0] r, input int from, input int excl);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (from + k) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [95:0] s, input logic f, input logic rs);
        int w;
        if (rs) begin
            m_gid = -1; m_ptr = 3; m_cnt = 0; m_led = '0;
            return;
        end
        m_led = (m_gid < 0) ? 24'h0 : s[m_gid*24 +: 24];
        if (m_gid < 0) begin
            m_cnt = 0;
            w = next_requester(r, m_ptr, -1);
            if (w >= 0) begin
                m_gid = w; m_ptr = w;
            end
        end else if (!r[m_gid]) begin
            m_gid = -1; m_cnt = 0;
        end else if (f) begin
            // slice timer paused
        end else if (m_cnt == DWELL - 1) begin
            m_cnt = 0;
            w = next_requester(r, m_ptr, m_gid);
            if (w >= 0) begin
                m_gid = w; m_ptr = w;
            end
        end else begin
            m_cnt = m_cnt + 1;
        end
    endtask

    function automatic logic [3:0] model_grant();
        return (m_gid < 0) ? 4'b0000 : 4'(1 << m_gid);
    endfunction

    task automatic compare_all();
        check_val("grant",     32'(grant),     32'(model_grant()));
        check_val("grant_id",  32'(grant_id),  (m_gid < 0) ? 32'd0 : 32'(m_gid));
        check_val("io_led",    32'(io_led),    32'(m_led));
        check_val("cnt",       32'(dbg_cnt),   32'(m_cnt));
        check_val("state",     32'(dbg_state), (m_gid < 0) ? 32'd0 : 32'd1);
        check_val("onehot",    32'($countones(grant) <= 1), 32'd1);
    endtask

    // ---------------- driver ----------------
    // Inputs change just after the falling edge; outputs are compared at the
    // next falling edge, after the rising edge that consumed those inputs.
    task automatic drive_cycle(input logic [3:0] r, input logic f, input logic rs);
        req      = r;
        freeze   = f;
        rst      = rs;
        src_data = {$urandom, $urandom, $urandom};
        model_step(r, src_data, f, rs);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        drive_cycle(4'b0000, 1'b0, 1'b1);
        drive_cycle(4'b0000, 1'b0, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [95:0] s_save;
        int wraps;
        logic [25:0] prev_cnt;

        req = '0; freeze = 1'b0; rst = 1'b1; src_data = '0;
        m_gid = -1; m_ptr = 3; m_cnt = 0; m_led = '0;
        @(negedge clk);

        // Reset state
        do_reset();
        check_val("rst_grant",  32'(grant),  32'd0);
        check_val("rst_io_led", 32'(io_led), 32'd0);

        // Sources 1 and 2 request: source 1 wins from ptr=3; LEDs follow.
        drive_cycle(4'b0110, 1'b0, 1'b0);
        check_val("first_grant", 32'(grant), 32'h2);
        drive_cycle(4'b0110, 1'b0, 1'b0);
        s_save = src_data;
        check_val("first_led", 32'(io_led), 32'(s_save[47:24]));

        // All request: each source in turn for exactly DWELL cycles.
        do_reset();
        for (int i = 0; i < 5 * DWELL; i++) begin
            drive_cycle(4'b1111, 1'b0, 1'b0);
            check_val("rotate_all", 32'(grant), 32'(1 << ((i / DWELL) % 4)));
        end

        // Release of source 2 with source 0 waiting: one idle cycle, then 0.
        do_reset();
        drive_cycle(4'b0100, 1'b0, 1'b0);
        check_val("src2_grant", 32'(grant), 32'h4);
        drive_cycle(4'b0001, 1'b0, 1'b0);
        check_val("drop_gap_grant", 32'(grant), 32'h0);
        drive_cycle(4'b0001, 1'b0, 1'b0);
        check_val("after_gap_grant", 32'(grant), 32'h1);
        check_val("gap_led", 32'(io_led), 32'h0);

        // Freeze from cnt=1: grant stays put, rotation 3 cycles after release.
        do_reset();
        drive_cycle(4'b0011, 1'b0, 1'b0);
        drive_cycle(4'b0011, 1'b0, 1'b0);
        check_val("frz_cnt1", 32'(dbg_cnt), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive_cycle(4'b0011, 1'b1, 1'b0);
            check_val("frz_hold", 32'(grant), 32'h1);
        end
        drive_cycle(4'b0011, 1'b0, 1'b0);
        check_val("unfrz_1", 32'(grant), 32'h1);
        drive_cycle(4'b0011, 1'b0, 1'b0);
        check_val("unfrz_2", 32'(grant), 32'h1);
        drive_cycle(4'b0011, 1'b0, 1'b0);
        check_val("unfrz_3", 32'(grant), 32'h2);

        // Lone requester: grant kept, counter wraps 3 -> 0 without a gap.
        do_reset();
        wraps = 0;
        prev_cnt = '0;
        for (int i = 0; i < 3 * DWELL + 1; i++) begin
            drive_cycle(4'b0010, 1'b0, 1'b0);
            check_val("lone_grant", 32'(grant), 32'h2);
            if (i > 0 && prev_cnt == 26'(DWELL - 1) && dbg_cnt == 26'd0) wraps++;
            prev_cnt = dbg_cnt;
        end
        check_val("lone_wraps", 32'(wraps), 32'd3);

        // Reset during HOLD on source 3.
        do_reset();
        drive_cycle(4'b1000, 1'b0, 1'b0);
        drive_cycle(4'b1000, 1'b0, 1'b0);
        check_val("s3_grant", 32'(grant), 32'h8);
        drive_cycle(4'b1000, 1'b0, 1'b1);
        check_val("midrst_grant", 32'(grant), 32'h0);
        check_val("midrst_led", 32'(io_led), 32'h0);
        drive_cycle(4'b1000, 1'b0, 1'b0);
        check_val("postrst_grant", 32'(grant), 32'h8);

        // Random traffic: requests mostly sticky so slices actually expire.
        begin
            logic [3:0] r;
            r = 4'b0000;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
                drive_cycle(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
